dmem_port: RTL and testbench

Downstream of the store buffer: accepts the committed-store stream (one store per cycle, no backpressure) plus load requests from the load unit, and arbitrates both onto the single-ported 16-bit data memory. Committed stores wait in a small write queue. Loads that hit a queued store are forwarded from the queue instead of reading stale memory. All load responses come back in order, at a fixed latency, whether they were served by memory or by forwarding.

---
 rtl/dmem_port_pkg.sv | 22 ++
 rtl/dmem_wq.sv | 90 +++++++++
 rtl/dmem_port.sv | 117 +++++++++++
 tb/tb_dmem_port.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_pkg.sv
// Shared types and widths for the data-memory port: request encoding,
// address/data widths and the load-response pipeline entry.
package dmem_port_pkg;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 16;
    // Pipeline tags are carried at this width; the top narrows to its TAG_W.
    localparam int TAG_MAX_W = 8;

    typedef enum logic {
        MEM_RD = 1'b0,
        MEM_WR = 1'b1
    } mem_op_e;

    typedef struct packed {
        logic                 valid;
        logic                 fwd;
        logic [TAG_MAX_W-1:0] tag;
        logic [DATA_W-1:0]    fwd_data;
    } resp_entry_t;

endpackage

// File: rtl/dmem_wq.sv
// Committed-store write queue: circular FIFO, youngest-match forwarding CAM,
// occupancy count, stall threshold and sticky overflow flag.
module dmem_wq
    import dmem_port_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        commit_valid,
    input  logic [ADDR_W-1:0]           commit_location,
    input  logic [DATA_W-1:0]           commit_data,
    input  logic                        deq,
    input  logic [ADDR_W-1:0]           ld_addr,
    output logic [ADDR_W-1:0]           head_addr,
    output logic [DATA_W-1:0]           head_data,
    output logic [$clog2(DEPTH):0]      count,
    output logic                        empty,
    output logic                        wq_stall,
    output logic                        wq_overflow,
    output logic                        fwd_hit,
    output logic [DATA_W-1:0]           fwd_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              full;
    logic              enq;

    assign full = (count_q == CNT_W'(DEPTH));
    // A same-cycle dequeue frees the slot the commit needs.
    assign enq  = commit_valid && (!full || deq);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (enq) begin
                addr_q[tail_q] <= commit_location;
                data_q[tail_q] <= commit_data;
                tail_q         <= tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (commit_valid && full && !deq) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Scan oldest to youngest so the last match wins; the incoming commit is youngest of all.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) && (addr_q[head_q + PTR_W'(k)] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[head_q + PTR_W'(k)];
            end
        end
        if (commit_valid && (commit_location == ld_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = commit_data;
        end
    end

    assign head_addr   = addr_q[head_q];
    assign head_data   = data_q[head_q];
    assign count       = count_q;
    assign empty       = (count_q == '0);
    assign wq_stall    = (count_q >= CNT_W'(DEPTH - 2));
    assign wq_overflow = overflow_q;

endmodule

// File: rtl/dmem_port.sv
// Data-memory port: arbitrates queued stores and loads onto one memory port,
// forwards loads from the write queue and returns responses in order at MEM_LAT.
module dmem_port
    import dmem_port_pkg::*;
#(
    parameter int WQ_DEPTH = 4,
    parameter int MEM_LAT  = 2,
    parameter int TAG_W    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              commit_valid,
    input  logic [ADDR_W-1:0] commit_location,
    input  logic [DATA_W-1:0] commit_data,
    output logic              wq_stall,
    output logic              wq_overflow,
    input  logic              ld_req_valid,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [TAG_W-1:0]  ld_tag,
    output logic              ld_req_ready,
    output logic              ld_resp_valid,
    output logic [DATA_W-1:0] ld_resp_data,
    output logic [TAG_W-1:0]  ld_resp_tag,
    output logic              mem_req_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_req_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(WQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] HI_WM = CNT_W'(WQ_DEPTH - 1);

    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [CNT_W-1:0]  wq_count;
    logic              wq_empty;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic              store_sel;
    logic              load_sel;
    logic              deq;
    logic              ld_acc;
    resp_entry_t       new_entry;
    resp_entry_t       pipe_q [MEM_LAT];
    resp_entry_t       pipe_out;

    dmem_wq #(
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk             (clk),
        .rst_n           (rst_n),
        .commit_valid    (commit_valid),
        .commit_location (commit_location),
        .commit_data     (commit_data),
        .deq             (deq),
        .ld_addr         (ld_addr),
        .head_addr       (head_addr),
        .head_data       (head_data),
        .count           (wq_count),
        .empty           (wq_empty),
        .wq_stall        (wq_stall),
        .wq_overflow     (wq_overflow),
        .fwd_hit         (fwd_hit),
        .fwd_data        (fwd_data)
    );

    // A forward hit never needs the memory port, so it cannot block a store.
    always_comb begin
        load_sel      = ld_req_valid && !flush && !fwd_hit;
        store_sel     = !wq_empty && ((wq_count >= HI_WM) || !load_sel);
        load_sel      = load_sel && !store_sel;
        mem_req_valid = store_sel || load_sel;
        mem_we        = store_sel ? MEM_WR : MEM_RD;
        mem_addr      = store_sel ? head_addr : (load_sel ? ld_addr : '0);
        mem_wdata     = store_sel ? head_data : '0;
        deq           = store_sel && mem_req_ready;
        ld_req_ready  = !flush && (fwd_hit || (!store_sel && mem_req_ready));
    end

    assign ld_acc = ld_req_valid && ld_req_ready;

    always_comb begin
        new_entry          = '0;
        new_entry.valid    = ld_acc;
        new_entry.fwd      = fwd_hit;
        new_entry.tag      = TAG_MAX_W'(ld_tag);
        new_entry.fwd_data = fwd_hit ? fwd_data : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= new_entry;
            for (int i = 1; i < MEM_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            if (flush) begin
                for (int i = 0; i < MEM_LAT; i++) begin
                    pipe_q[i].valid <= 1'b0;
                end
            end
        end
    end

    // Reads already in flight still return; flush only hides their data.
    assign pipe_out      = pipe_q[MEM_LAT-1];
    assign ld_resp_valid = pipe_out.valid && !flush;
    assign ld_resp_data  = ld_resp_valid ? (pipe_out.fwd ? pipe_out.fwd_data : mem_rdata) : '0;
    assign ld_resp_tag   = ld_resp_valid ? TAG_W'(pipe_out.tag) : '0;

endmodule

// File: tb/tb_dmem_port.sv
// Self-checking bench for dmem_port: architectural memory model, write-order
// and load-response scoreboards, directed scenarios then random traffic.
module tb_dmem_port;

    localparam int WQ_DEPTH = 4;
    localparam int MEM_LAT  = 2;
    localparam int TAG_W    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              commit_valid;
    logic [15:0]       commit_location;
    logic [15:0]       commit_data;
    logic              wq_stall;
    logic              wq_overflow;
    logic              ld_req_valid;
    logic [15:0]       ld_addr;
    logic [TAG_W-1:0]  ld_tag;
    logic              ld_req_ready;
    logic              ld_resp_valid;
    logic [15:0]       ld_resp_data;
    logic [TAG_W-1:0]  ld_resp_tag;
    logic              mem_req_valid;
    logic              mem_we;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_req_ready;
    logic [15:0]       mem_rdata;

    dmem_port #(
        .WQ_DEPTH (WQ_DEPTH),
        .MEM_LAT  (MEM_LAT),
        .TAG_W    (TAG_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush           (flush),
        .commit_valid    (commit_valid),
        .commit_location (commit_location),
        .commit_data     (commit_data),
        .wq_stall        (wq_stall),
        .wq_overflow     (wq_overflow),
        .ld_req_valid    (ld_req_valid),
        .ld_addr         (ld_addr),
        .ld_tag          (ld_tag),
        .ld_req_ready    (ld_req_ready),
        .ld_resp_valid   (ld_resp_valid),
        .ld_resp_data    (ld_resp_data),
        .ld_resp_tag     (ld_resp_tag),
        .mem_req_valid   (mem_req_valid),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_req_ready   (mem_req_ready),
        .mem_rdata       (mem_rdata)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- models and scoreboards ----------------
    logic [15:0] mem_arr [65536];
    logic [15:0] gold    [65536];
    logic [15:0] rd_pipe [MEM_LAT];
    logic [31:0] wr_exp_q [$];   // {addr, data} in commit order
    logic [51:0] exp_q [$];      // {due cycle, tag, data}
    logic        ovf_exp = 1'b0;
    logic        m_rd = 1'b0;
    logic        m_wr = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wdata = '0;

    assign mem_rdata = rd_pipe[MEM_LAT-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Single-ported memory: request captured mid-cycle, applied at the edge.
    always @(posedge clk) begin
        if (m_wr) mem_arr[m_addr] = m_wdata;
        for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] = rd_pipe[i-1];
        rd_pipe[0] = m_rd ? mem_arr[m_addr] : 16'h0;
    end

    always @(negedge clk) begin
        logic        wacc, racc, hit;
        int          sz;
        logic [31:0] w;
        logic [51:0] e;
        if (!rst_n) begin
            m_rd = 1'b0;
            m_wr = 1'b0;
        end else begin
            if (flush) begin
                chk("flush_kill", {31'b0, ld_resp_valid}, 32'd0);
                exp_q.delete();
            end else if (ld_resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("resp_spurious", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_tag", {28'b0, ld_resp_tag}, {28'b0, e[19:16]});
                    chk("resp_data", {16'b0, ld_resp_data}, {16'b0, e[15:0]});
                    chk("resp_cycle", cyc, e[51:20]);
                end
            end else if (exp_q.size() > 0 && int'(exp_q[0][51:20]) <= cyc) begin
                chk("resp_missing", 32'd0, 32'd1);
                void'(exp_q.pop_front());
            end

            wacc = mem_req_valid && mem_req_ready && mem_we;
            racc = mem_req_valid && mem_req_ready && !mem_we;
            sz   = wr_exp_q.size();
            chk("wq_stall", {31'b0, wq_stall}, {31'b0, sz >= WQ_DEPTH - 2});
            chk("wq_overflow", {31'b0, wq_overflow}, {31'b0, ovf_exp});

            hit = commit_valid && (commit_location == ld_addr);
            foreach (wr_exp_q[i]) if (wr_exp_q[i][31:16] == ld_addr) hit = 1'b1;

            if (wacc) begin
                if (sz == 0) begin
                    chk("write_spurious", 32'd1, 32'd0);
                end else begin
                    w = wr_exp_q.pop_front();
                    chk("write_addr", {16'b0, mem_addr}, {16'b0, w[31:16]});
                    chk("write_data", {16'b0, mem_wdata}, {16'b0, w[15:0]});
                end
            end

            if (commit_valid) begin
                if (sz == WQ_DEPTH && !wacc) begin
                    ovf_exp = 1'b1;
                end else begin
                    wr_exp_q.push_back({commit_location, commit_data});
                    gold[commit_location] = commit_data;
                end
            end

            if (ld_req_valid && flush) chk("flush_ready", {31'b0, ld_req_ready}, 32'd0);
            if (ld_req_valid && !flush && hit) chk("fwd_ready", {31'b0, ld_req_ready}, 32'd1);
            if (ld_req_valid && ld_req_ready) begin
                if (hit) chk("fwd_no_read", {31'b0, racc}, 32'd0);
                else     chk("load_read_issued", {31'b0, racc && (mem_addr == ld_addr)}, 32'd1);
                exp_q.push_back({32'(cyc + MEM_LAT), ld_tag, gold[ld_addr]});
            end

            m_rd    = racc;
            m_wr    = wacc;
            m_addr  = mem_addr;
            m_wdata = mem_wdata;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush        = 1'b0;
        commit_valid = 1'b0;
        ld_req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        idle_inputs();
        mem_req_ready = 1'b1;
        while (wr_exp_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk(name, wr_exp_q.size(), 32'd0);
        repeat (MEM_LAT + 1) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic stall_d1, stall_d2;
        for (int a = 0; a < 65536; a++) begin
            mem_arr[a] = 16'(a) ^ 16'hC3A5;
            gold[a]    = 16'(a) ^ 16'hC3A5;
        end
        for (int i = 0; i < MEM_LAT; i++) rd_pipe[i] = '0;
        rst_n = 1'b0;
        idle_inputs();
        commit_location = '0;
        commit_data     = '0;
        ld_addr         = '0;
        ld_tag          = '0;
        mem_req_ready   = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'b0, mem_wdata}, 32'd0);
        chk("rst_resp_valid", {31'b0, ld_resp_valid}, 32'd0);
        chk("rst_resp_data", {16'b0, ld_resp_data}, 32'd0);
        chk("rst_resp_tag", {28'b0, ld_resp_tag}, 32'd0);
        chk("rst_ld_req_ready", {31'b0, ld_req_ready}, 32'd1);
        tick();

        // Single commit drains next cycle
        commit_valid = 1'b1; commit_location = 16'h0010; commit_data = 16'hAAAA;
        tick();
        commit_valid = 1'b0;
        @(negedge clk);
        chk("t1_we", {31'b0, mem_req_valid && mem_we}, 32'd1);
        chk("t1_addr", {16'b0, mem_addr}, 32'h0010);
        chk("t1_wdata", {16'b0, mem_wdata}, 32'hAAAA);
        tick();
        @(negedge clk);
        chk("t1_empty", {31'b0, mem_req_valid}, 32'd0);
        tick();

        // Forward youngest of two queued stores to the same address
        mem_req_ready = 1'b0;
        commit_valid = 1'b1; commit_location = 16'h0020; commit_data = 16'h1111;
        tick();
        commit_data = 16'h2222;
        tick();
        commit_valid = 1'b0;
        ld_req_valid = 1'b1; ld_addr = 16'h0020; ld_tag = 4'd3;
        @(negedge clk);
        chk("t2_ld_ready", {31'b0, ld_req_ready}, 32'd1);
        chk("t2_no_read", {31'b0, mem_req_valid && !mem_we}, 32'd0);
        tick();
        ld_req_valid = 1'b0;
        repeat (MEM_LAT + 1) tick();
        drain("t2_drain");

        // Forward from the same-cycle commit
        commit_valid = 1'b1; commit_location = 16'h0030; commit_data = 16'hBEEF;
        ld_req_valid = 1'b1; ld_addr = 16'h0030; ld_tag = 4'd5;
        @(negedge clk);
        chk("t3_ld_ready", {31'b0, ld_req_ready}, 32'd1);
        tick();
        drain("t3_drain");

        // Fill, stall, overflow, FIFO-order drain
        mem_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            commit_valid = 1'b1; commit_location = 16'h0200 + 16'(i);
            commit_data = 16'($urandom_range(0, 65535));
            @(negedge clk);
            chk("t4_stall", {31'b0, wq_stall}, {31'b0, i >= 2});
            tick();
        end
        commit_valid = 1'b0;
        @(negedge clk);
        chk("t4_overflow", {31'b0, wq_overflow}, 32'd1);
        tick();
        drain("t4_drain");

        // Store priority at count 3, then loads
        mem_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            commit_valid = 1'b1; commit_location = 16'h0300 + 16'(i); commit_data = 16'h5000 + 16'(i);
            tick();
        end
        commit_valid = 1'b0; mem_req_ready = 1'b1;
        ld_req_valid = 1'b1; ld_addr = 16'h0310; ld_tag = 4'd1;
        @(negedge clk);
        chk("t5_store_first", {31'b0, mem_req_valid && mem_we}, 32'd1);
        chk("t5_ld_blocked", {31'b0, ld_req_ready}, 32'd0);
        tick();
        @(negedge clk);
        chk("t5_load_next", {31'b0, mem_req_valid && !mem_we}, 32'd1);
        chk("t5_load_addr", {16'b0, mem_addr}, 32'h0310);
        tick();
        for (int i = 0; i < 6; i++) begin
            ld_addr = 16'h0320 + 16'(i); ld_tag = 4'(2 + i);
            tick();
        end
        drain("t5_drain");

        // Flush kills two in-flight reads
        ld_req_valid = 1'b1; ld_addr = 16'h0400; ld_tag = 4'd6;
        tick();
        ld_addr = 16'h0401; ld_tag = 4'd7;
        tick();
        flush = 1'b1; ld_addr = 16'h0402; ld_tag = 4'd8;
        @(negedge clk);
        chk("t6_flush_ready", {31'b0, ld_req_ready}, 32'd0);
        tick();
        idle_inputs();
        for (int i = 0; i < MEM_LAT; i++) begin
            @(negedge clk);
            chk("t6_no_resp", {31'b0, ld_resp_valid}, 32'd0);
            tick();
        end
        ld_req_valid = 1'b1; ld_addr = 16'h0402; ld_tag = 4'd8;
        tick();
        ld_req_valid = 1'b0;
        repeat (MEM_LAT + 2) tick();

        // Random traffic; the store buffer reacts to stall two cycles late
        stall_d1 = 1'b0; stall_d2 = 1'b0;
        for (int n = 0; n < 600; n++) begin
            commit_valid    = !stall_d2 && ($urandom_range(0, 99) < 40);
            commit_location = 16'h0040 + 16'($urandom_range(0, 7));
            commit_data     = 16'($urandom_range(0, 65535));
            ld_req_valid    = ($urandom_range(0, 99) < 55);
            ld_addr         = 16'h0040 + 16'($urandom_range(0, 7));
            ld_tag          = 4'($urandom_range(0, 15));
            mem_req_ready   = ($urandom_range(0, 99) < 70);
            flush           = ($urandom_range(0, 99) < 3);
            stall_d2 = stall_d1;
            stall_d1 = wq_stall;
            tick();
        end
        drain("final_drain");
        chk("final_resp_q", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
